// File: rtl/mig_traffic_checker.sv
// MIG user-interface traffic checker: writes a pattern over an address window,
// reads it back in order, compares, and reports error / pass statistics.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   WR    | write sweep, one command + one data beat per address
//   RD    | read command sweep, back-to-back
//   DRAIN | waiting for outstanding reads to return
//   DONE  | single pass finished, results held
module mig_traffic_checker #(
    parameter int unsigned           ADDR_WIDTH     = 27,
    parameter int unsigned           APP_DATA_WIDTH = 256,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR     = 27'h0001ff0,
    parameter logic [ADDR_WIDTH-1:0] END_ADDR       = 27'h0002010,
    parameter int unsigned           ADDR_INC       = 8,
    parameter int unsigned           CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic                      continuous,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [CNT_WIDTH-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0]     first_err_addr,
    output logic [CNT_WIDTH-1:0]      pass_count,
    input  logic                      app_rdy,
    output logic                      app_en,
    output logic [2:0]                app_cmd,
    output logic [ADDR_WIDTH-1:0]     app_addr,
    input  logic                      app_wdf_rdy,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    input  logic                      app_rd_data_valid,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data
);

    localparam int unsigned NUM_CMDS = 32'((END_ADDR - START_ADDR) / ADDR_INC) + 1;
    localparam int unsigned OUT_W    = $clog2(NUM_CMDS) + 1;
    localparam int unsigned NREP     = APP_DATA_WIDTH / 32;
    localparam logic [ADDR_WIDTH-1:0] INC_A = ADDR_WIDTH'(ADDR_INC);
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] pat_word(input logic [1:0] m, input logic [31:0] seq,
                                             input logic [31:0] lfsr,
                                             input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] a32;
        a32 = 32'(a);
        case (m)
            2'd0:    return seq;
            2'd1:    return a32;
            2'd2:    return lfsr;
            default: return ~a32;
        endcase
    endfunction

    state_t                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic                      cont_q, cont_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic                      en_q, en_d;
    logic                      wren_q, wren_d;
    logic [2:0]                cmd_q, cmd_d;
    logic [APP_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [31:0]               wseq_q, wseq_d, wlfsr_q, wlfsr_d;
    logic [ADDR_WIDTH-1:0]     raddr_q, raddr_d;
    logic [31:0]               rseq_q, rseq_d, rlfsr_q, rlfsr_d;
    logic [OUT_W-1:0]          out_q, out_d;
    logic                      error_q, error_d;
    logic [CNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]     first_q, first_d;
    logic [CNT_WIDTH-1:0]      pass_q, pass_d;

    logic        cmd_acc, wr_step, addr_last, rd_issue, rd_ok, pass_end, launch, load_pass, mismatch;
    logic [31:0] exp_word;

    assign cmd_acc   = en_q & app_rdy;
    assign addr_last = (addr_q == END_ADDR);
    assign wr_step   = (state_q == S_WR) & (~en_q | app_rdy) & (~wren_q | app_wdf_rdy);
    assign rd_issue  = (state_q == S_RD) & cmd_acc;
    // Beats with nothing outstanding (e.g. stragglers from before a reset) are dropped.
    assign rd_ok     = app_rd_data_valid & ((state_q == S_RD) | (state_q == S_DRAIN)) & (out_q != '0);
    assign pass_end  = (state_q == S_DRAIN) & (out_q == '0);
    assign launch    = ((state_q == S_IDLE) | (state_q == S_DONE)) & start;
    assign load_pass = launch | (pass_end & cont_q);
    assign exp_word  = pat_word(mode_q, rseq_q, rlfsr_q, raddr_q);
    assign mismatch  = rd_ok & (app_rd_data != {NREP{exp_word}});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            cont_q    <= 1'b0;
            addr_q    <= START_ADDR;
            en_q      <= 1'b0;
            wren_q    <= 1'b0;
            cmd_q     <= CMD_WR;
            wdata_q   <= '0;
            wseq_q    <= '0;
            wlfsr_q   <= '0;
            raddr_q   <= START_ADDR;
            rseq_q    <= '0;
            rlfsr_q   <= '0;
            out_q     <= '0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            first_q   <= '0;
            pass_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cont_q    <= cont_d;
            addr_q    <= addr_d;
            en_q      <= en_d;
            wren_q    <= wren_d;
            cmd_q     <= cmd_d;
            wdata_q   <= wdata_d;
            wseq_q    <= wseq_d;
            wlfsr_q   <= wlfsr_d;
            raddr_q   <= raddr_d;
            rseq_q    <= rseq_d;
            rlfsr_q   <= rlfsr_d;
            out_q     <= out_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
            pass_q    <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_WR;
            S_WR:           if (wr_step && addr_last) state_d = S_RD;
            S_RD:           if (cmd_acc && addr_last) state_d = S_DRAIN;
            S_DRAIN:        if (out_q == '0) state_d = cont_q ? S_WR : S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mode_d    = mode_q;
        cont_d    = cont_q;
        addr_d    = addr_q;
        en_d      = en_q;
        wren_d    = wren_q;
        cmd_d     = cmd_q;
        wdata_d   = wdata_q;
        wseq_d    = wseq_q;
        wlfsr_d   = wlfsr_q;
        raddr_d   = raddr_q;
        rseq_d    = rseq_q;
        rlfsr_d   = rlfsr_q;
        out_d     = out_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        first_d   = first_q;
        pass_d    = pass_q;

        if (launch) begin
            mode_d = mode;
            cont_d = continuous;
        end

        if (rd_ok) begin
            raddr_d = raddr_q + INC_A;
            rseq_d  = rseq_q + 32'd1;
            rlfsr_d = lfsr_next(rlfsr_q);
        end
        if (mismatch) begin
            error_d = 1'b1;
            if (!error_q) first_d = raddr_q;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
        if (rd_issue && !rd_ok) out_d = out_q + OUT_W'(1);
        else if (!rd_issue && rd_ok) out_d = out_q - OUT_W'(1);
        if (pass_end) pass_d = pass_q + CNT_WIDTH'(1);

        if (load_pass) begin
            addr_d  = START_ADDR;
            en_d    = 1'b1;
            wren_d  = 1'b1;
            cmd_d   = CMD_WR;
            wseq_d  = 32'd1;
            wlfsr_d = 32'd1;
            wdata_d = {NREP{pat_word(mode_d, 32'd1, 32'd1, START_ADDR)}};
            raddr_d = START_ADDR;
            rseq_d  = 32'd1;
            rlfsr_d = 32'd1;
        end else if (state_q == S_WR) begin
            if (wr_step) begin
                en_d = 1'b1;
                if (addr_last) begin
                    addr_d = START_ADDR;
                    wren_d = 1'b0;
                    cmd_d  = CMD_RD;
                end else begin
                    addr_d  = addr_q + INC_A;
                    wren_d  = 1'b1;
                    wseq_d  = wseq_q + 32'd1;
                    wlfsr_d = lfsr_next(wlfsr_q);
                    wdata_d = {NREP{pat_word(mode_q, wseq_d, wlfsr_d, addr_d)}};
                end
            end else begin
                en_d   = en_q & ~app_rdy;
                wren_d = wren_q & ~app_wdf_rdy;
            end
        end else if (rd_issue) begin
            if (addr_last) begin
                addr_d = START_ADDR;
                en_d   = 1'b0;
            end else begin
                addr_d = addr_q + INC_A;
            end
        end
    end

    always_comb begin
        busy           = (state_q != S_IDLE) && (state_q != S_DONE);
        done           = (state_q == S_DONE);
        error          = error_q;
        err_count      = err_cnt_q;
        first_err_addr = first_q;
        pass_count     = pass_q;
        app_en         = en_q;
        app_cmd        = cmd_q;
        app_addr       = addr_q;
        app_wdf_wren   = wren_q;
        app_wdf_end    = wren_q;
        app_wdf_data   = wdata_q;
    end

endmodule

// File: tb/tb_mig_traffic_checker.sv
// Directed bench for mig_traffic_checker with a behavioural MIG memory model
// and a scoreboard of expected write beats.
module tb_mig_traffic_checker;

    localparam int AW = 27;
    localparam int DW = 256;
    localparam int CW = 2;
    localparam int LAT = 20;
    localparam int NCMD = 5;
    localparam logic [AW-1:0] S_A = 27'h0001ff0;
    localparam logic [AW-1:0] E_A = 27'h0002010;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1, start = 1'b0, continuous = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          busy, done, error;
    logic [CW-1:0] err_count, pass_count;
    logic [AW-1:0] first_err_addr, app_addr;
    logic          app_rdy, app_en, app_wdf_rdy, app_wdf_wren, app_wdf_end, app_rd_data_valid;
    logic [2:0]    app_cmd;
    logic [DW-1:0] app_wdf_data, app_rd_data;

    mig_traffic_checker #(
        .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .START_ADDR(S_A), .END_ADDR(E_A),
        .ADDR_INC(8), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .continuous(continuous),
        .busy(busy), .done(done), .error(error), .err_count(err_count),
        .first_err_addr(first_err_addr), .pass_count(pass_count),
        .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_data(app_wdf_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data(app_rd_data)
    );

    // Memory model state (written only by the model process)
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [AW-1:0] cmdq[$];
    logic [DW-1:0] datq[$];
    wr_t           wr_log[$];
    logic [AW-1:0] rdq_a[$];
    int            rdq_t[$];
    int            cyc = 0, rd_issued = 0, rt_cnt = 0;

    // Stimulus-controlled knobs
    logic rnd = 1'b0;
    int   cor_mode = 0;

    int   n_cmp = 0, n_fail = 0;
    wr_t  expq[$];

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [1:0] m, input int beat, input logic [AW-1:0] a);
        logic [31:0] w, l;
        l = 32'h1;
        for (int k = 0; k < beat; k++) l = lfsr_step(l);
        case (m)
            2'd0:    w = 32'(beat + 1);
            2'd1:    w = 32'(a);
            2'd2:    w = l;
            default: w = ~(32'(a));
        endcase
        return {(DW/32){w}};
    endfunction

    function automatic logic corrupt(input int mode_sel, input logic [AW-1:0] a, input int idx);
        if (mode_sel == 1) return a == 27'h0002000;
        if (mode_sel == 2) begin
            if (idx / NCMD == 0) return (a == 27'h0001ff8) || (a == 27'h0002010);
            return (a == 27'h0002008) || (a == 27'h0002010);
        end
        return 1'b0;
    endfunction

    // MIG model: inputs change at negedge; accepts recorded here happen at the next posedge.
    initial begin
        logic [AW-1:0] a;
        wr_t e;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                cmdq.delete();
                datq.delete();
                wr_log.delete();
                rd_issued = 0;
                rt_cnt = 0;
            end
            app_rdy     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            app_wdf_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            app_rd_data_valid = 1'b0;
            if (rdq_t.size() > 0 && rdq_t[0] <= cyc) begin
                a = rdq_a.pop_front();
                void'(rdq_t.pop_front());
                app_rd_data_valid = 1'b1;
                app_rd_data = mem.exists(a) ? mem[a] : '0;
                if (corrupt(cor_mode, a, rt_cnt)) app_rd_data[0] = ~app_rd_data[0];
                rt_cnt++;
            end
            if (!reset) begin
                if (app_en && app_rdy && app_cmd == 3'b000) cmdq.push_back(app_addr);
                if (app_wdf_wren && app_wdf_rdy) datq.push_back(app_wdf_data);
                if (app_en && app_rdy && app_cmd == 3'b001) begin
                    rdq_a.push_back(app_addr);
                    rdq_t.push_back(cyc + LAT);
                    rd_issued++;
                end
                while (cmdq.size() > 0 && datq.size() > 0) begin
                    e.a = cmdq.pop_front();
                    e.d = datq.pop_front();
                    mem[e.a] = e.d;
                    wr_log.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic c);
        mode = m;
        continuous = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && done !== 1'b1; n++) step();
    endtask

    task automatic push_exp(input logic [1:0] m);
        wr_t e;
        for (int i = 0; i < NCMD; i++) begin
            e.a = S_A + AW'(8 * i);
            e.d = exp_data(m, i, e.a);
            expq.push_back(e);
        end
    endtask

    task automatic cmp_writes(input string tag);
        wr_t o, e;
        check({tag, "_wr_count"}, DW'(wr_log.size()), DW'(expq.size()));
        while (expq.size() > 0 && wr_log.size() > 0) begin
            e = expq.pop_front();
            o = wr_log.pop_front();
            check({tag, "_wr_addr"}, DW'(o.a), DW'(e.a));
            check({tag, "_wr_data"}, o.d, e.d);
        end
        expq.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_app_en"}, DW'(app_en), '0);
        check({tag, "_wren"}, DW'({app_wdf_wren, app_wdf_end}), '0);
        check({tag, "_flags"}, DW'({busy, done, error}), '0);
        check({tag, "_app_cmd"}, DW'(app_cmd), '0);
        check({tag, "_app_addr"}, DW'(app_addr), DW'(S_A));
        check({tag, "_counts"}, DW'({err_count, pass_count}), '0);
        check({tag, "_first_err"}, DW'(first_err_addr), '0);
        check({tag, "_wdata"}, app_wdf_data, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        check_reset("por");
        reset = 1'b0;
        step();

        // Ideal memory, incrementing pattern; start and mode change mid-pass ignored
        push_exp(2'd0);
        pulse_start(2'd0, 1'b0);
        check("t1_busy", DW'(busy), DW'(1));
        step();
        mode = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(500);
        check("t1_done", DW'(done), DW'(1));
        cmp_writes("t1");
        check("t1_reads", DW'(rd_issued), DW'(NCMD));
        check("t1_error", DW'(error), '0);
        check("t1_err_count", DW'(err_count), '0);
        check("t1_pass_count", DW'(pass_count), DW'(1));
        check("t1_busy_end", DW'(busy), '0);

        // Random backpressure, LFSR pattern
        do_reset();
        rnd = 1'b1;
        push_exp(2'd2);
        pulse_start(2'd2, 1'b0);
        wait_done(3000);
        rnd = 1'b0;
        check("t2_done", DW'(done), DW'(1));
        for (int i = 0; i < NCMD; i++)
            check($sformatf("t2_mem%0d", i), mem[S_A + AW'(8 * i)], exp_data(2'd2, i, S_A + AW'(8 * i)));
        cmp_writes("t2");
        check("t2_reads", DW'(rd_issued), DW'(NCMD));
        check("t2_error", DW'(error), '0);
        check("t2_pass_count", DW'(pass_count), DW'(1));

        // Single corrupted read at 0x2000, address pattern
        do_reset();
        cor_mode = 1;
        push_exp(2'd1);
        pulse_start(2'd1, 1'b0);
        wait_done(500);
        check("t3_done", DW'(done), DW'(1));
        cmp_writes("t3");
        check("t3_error", DW'(error), DW'(1));
        check("t3_err_count", DW'(err_count), DW'(1));
        check("t3_first_err", DW'(first_err_addr), DW'(27'h0002000));

        // Restart from DONE keeps counters and the sticky error
        cor_mode = 0;
        pulse_start(2'd1, 1'b0);
        wait_done(500);
        check("t3b_done", DW'(done), DW'(1));
        check("t3b_pass_count", DW'(pass_count), DW'(2));
        check("t3b_err_count", DW'(err_count), DW'(1));
        check("t3b_error", DW'(error), DW'(1));
        check("t3b_first_err", DW'(first_err_addr), DW'(27'h0002000));

        // Continuous, inverted address, two corruptions per pass: saturation at 3
        do_reset();
        cor_mode = 2;
        pulse_start(2'd3, 1'b1);
        for (int n = 0; n < 1000 && pass_count !== 2'd3; n++) step();
        check("t4_pass_count", DW'(pass_count), DW'(3));
        check("t4_err_count", DW'(err_count), DW'(3));
        check("t4_first_err", DW'(first_err_addr), DW'(27'h0001ff8));
        check("t4_error", DW'(error), DW'(1));
        check("t4_still_busy", DW'({busy, done}), DW'(2'b10));
        do_reset();
        cor_mode = 0;
        for (int n = 0; n < 200 && rdq_a.size() != 0; n++) step();

        // Reset in RD with three reads outstanding; late beats must be ignored
        pulse_start(2'd0, 1'b0);
        for (int n = 0; n < 200 && rd_issued < 3; n++) step();
        step();
        check("t5_in_rd", DW'({busy, app_en, app_cmd}), DW'(5'b11001));
        reset = 1'b1;
        step();
        check_reset("t5_rst");
        reset = 1'b0;
        for (int n = 0; n < 200 && rdq_a.size() != 0; n++) step();
        step();
        check("t5_drained", DW'(rdq_a.size()), '0);
        check("t5_late_error", DW'(error), '0);
        check("t5_late_count", DW'(err_count), '0);
        check("t5_idle", DW'({busy, done}), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
